// File: rtl/fetch_pkg.sv
// Shared widths and the fetch-queue entry layout for the instruction fetch stage.
package fetch_pkg;
   localparam int XLEN  = 64;
   localparam int ILEN  = 32;
   localparam int DEPTH = 4;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      logic            filled;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction-memory request/response and fetch-to-decode signals of the IF stage.
interface fetch_if;
   import fetch_pkg::*;

   // valid/ready: a transfer happens on a rising edge where both are high; the
   // sender keeps valid and payload stable until then, and ready may depend on nothing
   // from the same transfer. The response channel has no ready and is in request order.
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_req_addr;
   logic            imem_resp_valid;
   logic [ILEN-1:0] imem_resp_data;
   logic            if_valid;
   logic [XLEN-1:0] if_pc;
   logic [ILEN-1:0] if_instr;
   logic            id_ready;

   modport master (
      output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      input  imem_req_ready, imem_resp_valid, imem_resp_data, id_ready
   );

   modport slave (
      input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
      output imem_req_ready, imem_resp_valid, imem_resp_data, id_ready
   );
endinterface

// File: rtl/fetch_queue.sv
// In-order circular fetch queue: entries are allocated at issue, filled in order by
// memory responses, and popped from the head once filled.
module fetch_queue
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            clear,
   input  logic            alloc,
   input  logic [XLEN-1:0] alloc_pc,
   input  logic            fill,
   input  logic [ILEN-1:0] fill_instr,
   input  logic            pop,
   output logic            head_valid,
   output logic [XLEN-1:0] head_pc,
   output logic [ILEN-1:0] head_instr,
   output logic [CW-1:0]   count,
   output logic [CW-1:0]   unfilled
);
   fetch_entry_t  mem [DEPTH];
   logic [PW-1:0] head, tail, fptr;
   logic [CW-1:0] nfill;

   always_comb begin
      head_valid = (count != '0) & mem[head].filled;
      head_pc    = mem[head].pc;
      head_instr = mem[head].instr;
      unfilled   = count - nfill;
   end

   // fill only ever targets an allocated unfilled slot and alloc a free one, so the
   // three pointers never write the same entry in one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         fptr  <= '0;
         count <= '0;
         nfill <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         head  <= '0;
         tail  <= '0;
         fptr  <= '0;
         count <= '0;
         nfill <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
      end else begin
         if (alloc) begin
            mem[tail] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
            tail      <= tail + PW'(1);
         end
         if (fill) begin
            mem[fptr].instr  <= fill_instr;
            mem[fptr].filled <= 1'b1;
            fptr             <= fptr + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         count <= count + CW'(alloc) - CW'(pop);
         nfill <= nfill + CW'(fill) - CW'(pop);
      end
   end
endmodule

// File: rtl/fetch_stage.sv
// IF stage: issues one in-order imem read per accepted PC, buffers returned words and
// hands {pc, instr} to decode; a branch flush discards queued and in-flight reads.
module fetch_stage
   import fetch_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_write,
   input  logic            flush,
   fetch_if.master         bus,
   output logic [CW-1:0]   dbg_drop_cnt,
   output logic [CW-1:0]   dbg_count
);
   logic [CW-1:0] count, unfilled, drop_cnt;
   logic [CW:0]   pending;
   logic          req_fire, resp_drop, resp_fill, resp_stray, pop;

   always_comb begin
      bus.imem_req_valid = ~reset & ~flush & (count < CW'(DEPTH));
      bus.imem_req_addr  = pc_in;
      req_fire           = bus.imem_req_valid & bus.imem_req_ready;
      pc_write           = req_fire | (flush & ~reset);
      pop                = bus.if_valid & bus.id_ready;
      resp_drop          = bus.imem_resp_valid & (drop_cnt != '0);
      resp_fill          = bus.imem_resp_valid & (drop_cnt == '0) & (unfilled != '0);
      resp_stray         = bus.imem_resp_valid & (drop_cnt == '0) & (unfilled == '0);
      // Every read still outstanding after this edge becomes a response to discard.
      pending            = {1'b0, unfilled} + {1'b0, drop_cnt}
                         - (CW + 1)'(resp_drop | resp_fill);
      dbg_drop_cnt       = drop_cnt;
      dbg_count          = count;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)          drop_cnt <= '0;
      else if (flush)     drop_cnt <= pending[CW-1:0];
      else if (resp_drop) drop_cnt <= drop_cnt - CW'(1);
   end

   fetch_queue u_queue (
      .clk        (clk),
      .reset      (reset),
      .clear      (flush),
      .alloc      (req_fire),
      .alloc_pc   (pc_in),
      .fill       (resp_fill),
      .fill_instr (bus.imem_resp_data),
      .pop        (pop),
      .head_valid (bus.if_valid),
      .head_pc    (bus.if_pc),
      .head_instr (bus.if_instr),
      .count      (count),
      .unfilled   (unfilled)
   );

   always @(posedge clk) begin
      if (!reset) begin
         assert (!resp_stray) else $error("fetch_stage: imem response with no read outstanding");
         assert (!(flush && pending[CW])) else $error("fetch_stage: drop counter overflow");
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with an in-order memory and PC_Unit model.
module tb_fetch_stage;
   import fetch_pkg::*;

   typedef struct {
      logic [XLEN-1:0] addr;
      int              due;
      int              epoch;
   } req_t;

   typedef struct {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
      bit              got;
   } ent_t;

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic            flush = 1'b0;
   logic [XLEN-1:0] pc_in = '0;
   logic            pc_write;
   logic [CW-1:0]   dbg_drop_cnt, dbg_count;

   fetch_if bus ();

   fetch_stage dut (
      .clk          (clk),
      .reset        (reset),
      .pc_in        (pc_in),
      .pc_write     (pc_write),
      .flush        (flush),
      .bus          (bus),
      .dbg_drop_cnt (dbg_drop_cnt),
      .dbg_count    (dbg_count)
   );

   always #5 clk = ~clk;

   // memory side: every accepted read, oldest first, tagged with its fetch epoch
   req_t out_q[$];
   // decode side: reads issued since the last flush/reset, in program order
   ent_t dec_q[$];

   int              checks = 0;
   int              errors = 0;
   int              cyc = 0;
   int              cur_epoch = 0;
   int              first_valid = -1;
   int              lat = 0;
   logic [XLEN-1:0] pc_model = '0;
   logic [XLEN-1:0] flush_target = '0;
   logic [ILEN-1:0] mix = '0;
   bit              flush_n = 0;
   bit              idr_n = 1;
   bit              rdy_n = 1;

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic step();
      bit              resp, exp_valid, exp_rv, exp_fire;
      int              stale;
      logic [ILEN-1:0] rdata;
      req_t            r;
      @(negedge clk);
      flush              = flush_n;
      bus.id_ready       = idr_n;
      bus.imem_req_ready = rdy_n;
      pc_in              = pc_model;
      resp  = (out_q.size() > 0) && (out_q[0].due <= cyc);
      rdata = resp ? (out_q[0].addr[ILEN-1:0] ^ mix) : ILEN'($urandom);
      bus.imem_resp_valid = resp;
      bus.imem_resp_data  = rdata;
      #1;
      exp_valid = (dec_q.size() > 0) && dec_q[0].got;
      chk("if_valid", 64'(bus.if_valid), 64'(exp_valid));
      if (exp_valid) begin
         chk("if_pc", 64'(bus.if_pc), 64'(dec_q[0].pc));
         chk("if_instr", 64'(bus.if_instr), 64'(dec_q[0].instr));
         if (first_valid < 0) first_valid = cyc;
      end
      exp_rv = !flush_n && (dec_q.size() < DEPTH);
      chk("req_valid", 64'(bus.imem_req_valid), 64'(exp_rv));
      if (exp_rv) chk("req_addr", 64'(bus.imem_req_addr), 64'(pc_model));
      exp_fire = exp_rv && rdy_n;
      chk("pc_write", 64'(pc_write), 64'(exp_fire || flush_n));
      stale = 0;
      foreach (out_q[i]) if (out_q[i].epoch != cur_epoch) stale++;
      chk("drop_cnt", 64'(dbg_drop_cnt), 64'(stale));
      chk("count", 64'(dbg_count), 64'(dec_q.size()));

      // effects of the coming rising edge
      if (exp_valid && idr_n) void'(dec_q.pop_front());
      if (resp) begin
         r = out_q.pop_front();
         if (r.epoch == cur_epoch) begin
            for (int i = 0; i < dec_q.size(); i++) begin
               if (!dec_q[i].got) begin
                  dec_q[i].got   = 1;
                  dec_q[i].instr = rdata;
                  break;
               end
            end
         end
      end
      if (flush_n) begin
         cur_epoch++;
         dec_q.delete();
         pc_model = flush_target;
      end else if (exp_fire) begin
         out_q.push_back('{addr: pc_model, due: cyc + 1 + lat, epoch: cur_epoch});
         dec_q.push_back('{pc: pc_model, instr: '0, got: 0});
         pc_model = pc_model + 64'd4;
      end
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(int hold);
      flush_n = 0;
      flush   = 1'b0;
      bus.imem_resp_valid = 1'b0;
      #3 reset = 1'b1;
      #1;
      chk("rst_if_valid", 64'(bus.if_valid), 64'd0);
      chk("rst_if_pc", 64'(bus.if_pc), 64'd0);
      chk("rst_if_instr", 64'(bus.if_instr), 64'd0);
      chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
      chk("rst_pc_write", 64'(pc_write), 64'd0);
      chk("rst_drop_cnt", 64'(dbg_drop_cnt), 64'd0);
      out_q.delete();
      dec_q.delete();
      cur_epoch++;
      repeat (hold) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   initial begin
      bus.id_ready        = 1'b1;
      bus.imem_req_ready  = 1'b1;
      bus.imem_resp_valid = 1'b0;
      bus.imem_resp_data  = '0;

      // streaming from pc 0 with a zero-wait memory returning the address as data
      do_reset(2);
      run(10);
      chk("first_valid_cycle", 64'(first_valid), 64'd2);

      // decode stall fills the queue, then drains in order
      mix = 32'hC0DE_0000;
      idr_n = 0;
      run(5);
      chk("full_count", 64'(dbg_count), 64'(DEPTH));
      idr_n = 1;
      run(8);

      // memory not ready for three cycles
      rdy_n = 0;
      run(3);
      rdy_n = 1;
      run(6);

      // flush with reads in flight on a one-wait memory
      lat = 1;
      run(6);
      flush_target = 64'd100;
      flush_n = 1;
      run(1);
      flush_n = 0;
      run(10);

      // flush landing on a response cycle
      run(3);
      flush_target = 64'h2000;
      flush_n = 1;
      run(1);
      flush_n = 0;
      run(8);

      // reset while decode stalls with entries buffered
      lat = 0;
      idr_n = 0;
      run(5);
      chk("pre_reset_valid", 64'(bus.if_valid), 64'd1);
      do_reset(2);
      idr_n = 1;
      run(8);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         idr_n = ($urandom_range(0, 3) != 0);
         rdy_n = ($urandom_range(0, 3) != 0);
         lat   = $urandom_range(0, 2);
         flush_n = ($urandom_range(0, 19) == 0) && (out_q.size() < 6);
         flush_target = 64'({$urandom_range(0, 4095), 2'b00});
         step();
      end
      flush_n = 0;
      idr_n = 1;
      rdy_n = 1;
      lat = 0;
      run(12);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage directly downstream of PC_Unit.
- Each cycle it consumes the current PC and issues an in-order instruction-memory read.
- Tracks in-flight reads and buffers returned instructions in a small queue.
- Presents {pc, instr} to decode with a valid/ready handshake; drives PC_Unit's PCWrite (back-pressure) and flushes on BranchTaken.

Parameters:
- XLEN, 64, PC width.
- ILEN, 32, instruction width.
- DEPTH, 4, fetch-queue entries (power of 2, ≥2); also caps outstanding reads.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_in  in  XLEN  current PC from PC_Unit.
- pc_write  out  1  to PC_Unit PCWrite.
- flush  in  1  BranchTaken from EX; same cycle PC_Unit loads BranchTarget.
- imem_req_valid  out  1  read request.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  read address.
- imem_resp_valid  in  1  in-order read data valid.
- imem_resp_data  in  ILEN  instruction word.
- if_valid  out  1  head entry available to decode.
- if_pc  out  XLEN  PC of head entry.
- if_instr  out  ILEN  instruction of head entry.
- id_ready  in  1  decode accepts (0 = stall).

Behaviour:
- Reset, async, any cycle:
  - Queue empty; drop counter 0.
  - if_valid=0, if_pc=0, if_instr=0, imem_req_valid=0, pc_write=0.
  - Reset mid-transfer discards everything.
- Entry fields: pc, instr, filled. The queue keeps allocation order.
- Issue:
  - imem_req_valid = ~flush & (count < DEPTH). Count is registered (allocated entries), so there is no combinational id_ready→request path.
  - imem_req_addr = pc_in.
  - req_fire = imem_req_valid & imem_req_ready. Fire allocates an entry {pc_in, filled=0} at the tail.
- pc_write = req_fire | flush. PC advances exactly once per accepted request. The flush term guarantees the target load regardless of PCWrite gating in PC_Unit.
- Response:
  - If drop_cnt>0, drop_cnt decrements and the data is discarded.
  - Otherwise it fills the oldest unfilled entry.
  - A response with no unfilled entry and drop_cnt=0 is a protocol error: it is ignored and flagged by a simulation-only assertion.
- Output:
  - if_valid = head entry present & filled.
  - if_pc/if_instr come from the head entry; they hold stable while if_valid & ~id_ready.
  - Pop on if_valid & id_ready.
- Latency with a 0-wait memory (resp one cycle after fire) and id_ready=1:
  - Request cycle N, response N+1, if_valid N+2.
  - Sustains 1 instruction/cycle at DEPTH≥3.
- Flush, highest priority:
  - At the edge, all entries are invalidated.
  - drop_cnt ← (allocated-but-unfilled entries) − (1 if a non-dropped response arrives this cycle) + (existing drop_cnt − 1 if a dropped response arrives this cycle).
  - No request in the flush cycle. if_valid is 0 from the next cycle until new responses arrive.
  - A pop in the flush cycle is still honoured (decode's own squash handles it).
- While drop_cnt>0, new requests may issue; their responses are matched only after drop_cnt reaches 0.
- drop_cnt width: clog2(DEPTH)+1 bits.
- Simultaneous alloc + fill + pop in one cycle is legal; count updates by alloc − pop.
- Full (count=DEPTH): no request; pc_write=0 (PC stalls).
- Pointers wrap modulo DEPTH.

Decomposition:
- Package fetch_pkg: XLEN, ILEN, DEPTH defaults; struct fetch_entry_t {pc, instr, filled}.
- Sub-module fetch_queue:
  - Circular buffer with head/tail/fill pointers and count.
  - alloc/fill/pop/clear ports.
  - fetch_stage keeps issue logic, drop counter and handshakes.

Test Plan:
- Reset held 2 cycles then released; pc_in=0, memory always ready, resp=4*index → requests at 0,4,8…; if_valid from cycle 2; if_pc/if_instr pairs 0/0x0, 4/0x4, 8/0x8, one per cycle.
- id_ready=0 for 5 cycles → queue fills to 4; imem_req_valid=0 and pc_write=0 while full; if_pc holds; on release, PCs continue in order with no gap or duplicate.
- imem_req_ready low 3 cycles → pc_write=0 those cycles; PC not skipped; address sequence contiguous.
- flush with 2 reads in flight while pc_in→100 → next two responses dropped; first if_valid shows if_pc=100 with the 100-address instruction; no pre-flush PC ever visible after flush.
- flush and a response in the same cycle, one other read outstanding → exactly one later response dropped; drop_cnt returns to 0.
- Reset asserted mid-stream with 3 entries valid → if_valid falls asynchronously; after release, fetch restarts cleanly from the current pc_in.
